rx_frame_assembler: RTL and testbench

- Parametrised successor to the 3-byte receive buffer. Collects DATA_W-bit words from an upstream byte receiver (UART/SPI RX) into a NUM_BYTES-wide frame.
- Adds internal edge detection on the strobe, a valid/ready output handshake with double buffering, an inactivity timeout, and overrun reporting.
- Sits between the serial receiver and command decode logic.

---
 rtl/rx_frame_assembler.sv | 209 ++++++++++++++++++++
 tb/tb_rx_frame_assembler.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_assembler.sv
// rx_frame_assembler
//   Collects DATA_W-bit words from an upstream byte receiver (UART/SPI RX)
//   into a NUM_BYTES-word frame and hands it to command decode logic through
//   a double-buffered valid/ready output register.
//
//   Features: rising-edge detection on the level strobe, inactivity timeout
//   that discards a partial frame, sticky overrun when a completed frame
//   cannot be stored, and an optional trailing XOR checksum word.
//
//   Optional feature macro: RX_FRAME_CHECKSUM_EN
//     defined   : each frame is NUM_BYTES data words plus one XOR checksum word;
//                 a mismatch discards the frame and pulses o_chk_err.
//     undefined : no checksum word, o_chk_err tied low.
//
//   Parameters: DATA_W, NUM_BYTES (1..64), TIMEOUT_CYC (0 = no timeout), MSB_FIRST
//
//   Ports:
//     clk            clock
//     rst            synchronous active-low reset
//     i_byte_strobe  level "word done"; only its rising edge counts
//     i_byte_in      received word, valid when the strobe rises
//     o_frame_out    assembled frame, stable while o_frame_valid=1
//     o_frame_valid  frame available
//     i_frame_ready  consumer accepts frame when valid & ready
//     o_byte_count   words held in the partial frame
//     o_overrun      sticky: a completed frame was dropped
//     o_timeout_err  1-cycle pulse: partial frame discarded by timeout
//     o_chk_err      1-cycle pulse: checksum mismatch
//     i_clear_err    clears o_overrun (a same-cycle set wins)
module rx_frame_assembler #(
  parameter int DATA_W      = 8,
  parameter int NUM_BYTES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MSB_FIRST   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_byte_strobe,
  input  logic [DATA_W-1:0]              i_byte_in,
  output logic [DATA_W*NUM_BYTES-1:0]    o_frame_out,
  output logic                           o_frame_valid,
  input  logic                           i_frame_ready,
  output logic [$clog2(NUM_BYTES+1)-1:0] o_byte_count,
  output logic                           o_overrun,
  output logic                           o_timeout_err,
  output logic                           o_chk_err,
  input  logic                           i_clear_err
);

  localparam int FW = DATA_W * NUM_BYTES;
  localparam int CW = $clog2(NUM_BYTES + 1);
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : {TW{1'b0}};

`ifdef RX_FRAME_CHECKSUM_EN
  // The checksum word occupies the slot after the last data word.
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_BYTES);

  // XOR of all data words held in a frame image.
  function automatic logic [DATA_W-1:0] f_xor_words(input logic [FW-1:0] frame);
    logic [DATA_W-1:0] acc;
    acc = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_BYTES; k++) begin
      acc = acc ^ frame[DATA_W*k +: DATA_W];
    end
    return acc;
  endfunction
`else
  localparam logic [CW-1:0] LAST_SLOT = CW'(NUM_BYTES - 1);
`endif

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_t;

  logic              r_strobe_q;
  logic [CW-1:0]     r_count;
  logic [FW-1:0]     r_stage;
  logic [TW-1:0]     r_timer;
  logic              r_timeout_err;
  logic              r_chk_err;
  out_state_t        r_state;
  logic [FW-1:0]     r_frame;
  logic              r_overrun;

  logic              w_edge;
  logic              w_at_last;
  logic [FW-1:0]     w_stage_ins;
  logic [FW-1:0]     w_new_frame;
  logic              w_complete;
  logic              w_chk_bad;
  logic              w_expire;
  logic              w_drop;

  assign w_edge    = i_byte_strobe & ~r_strobe_q;
  assign w_at_last = (r_count == LAST_SLOT);

  // Staging image with the incoming word dropped into slot r_count.
  for (genvar k = 0; k < NUM_BYTES; k++) begin : g_slot
    localparam int POS = (MSB_FIRST != 0) ? (NUM_BYTES - 1 - k) : k;
    assign w_stage_ins[DATA_W*POS +: DATA_W] =
      (r_count == CW'(k)) ? i_byte_in : r_stage[DATA_W*POS +: DATA_W];
  end

`ifdef RX_FRAME_CHECKSUM_EN
  logic w_chk_ok;
  assign w_chk_ok    = (f_xor_words(r_stage) == i_byte_in);
  assign w_complete  = w_edge & w_at_last & w_chk_ok;
  assign w_chk_bad   = w_edge & w_at_last & ~w_chk_ok;
  assign w_new_frame = r_stage;
`else
  assign w_complete  = w_edge & w_at_last;
  assign w_chk_bad   = 1'b0;
  assign w_new_frame = w_stage_ins;
`endif

  // A strobe edge in the expiry cycle takes priority over the timeout.
  if (TIMEOUT_CYC > 0) begin : g_tmo
    assign w_expire = (r_count != {CW{1'b0}}) & ~w_edge & (r_timer == TMO_LAST);
  end else begin : g_no_tmo
    assign w_expire = 1'b0;
  end

  // A completed frame is dropped when the output holds a frame not being accepted.
  assign w_drop = (r_state == ST_FULL) & w_complete & ~i_frame_ready;

  // Word collection: edge detect, slot counter, staging register and timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_strobe_q    <= 1'b0;
      r_count       <= {CW{1'b0}};
      r_stage       <= {FW{1'b0}};
      r_timer       <= {TW{1'b0}};
      r_timeout_err <= 1'b0;
      r_chk_err     <= 1'b0;
    end else begin
      r_strobe_q    <= i_byte_strobe;
      r_timeout_err <= w_expire;
      r_chk_err     <= w_chk_bad;
      if (w_edge) begin
        r_timer <= {TW{1'b0}};
        if (w_at_last) begin
          r_count <= {CW{1'b0}};
          r_stage <= {FW{1'b0}};
        end else begin
          r_count <= r_count + CW'(1);
          r_stage <= w_stage_ins;
        end
      end else if (w_expire) begin
        r_count <= {CW{1'b0}};
        r_stage <= {FW{1'b0}};
        r_timer <= {TW{1'b0}};
      end else if ((TIMEOUT_CYC > 0) && (r_count != {CW{1'b0}})) begin
        r_timer <= r_timer + TW'(1);
      end else begin
        r_timer <= {TW{1'b0}};
      end
    end
  end

  // Output register FSM (EMPTY/FULL) with overrun tracking.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_EMPTY;
      r_frame   <= {FW{1'b0}};
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_complete) begin
            r_state <= ST_FULL;
            r_frame <= w_new_frame;
          end else begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_complete && i_frame_ready) begin
            r_state <= ST_FULL;
            r_frame <= w_new_frame;
          end else if (i_frame_ready) begin
            r_state <= ST_EMPTY;
          end else begin
            r_state <= ST_FULL;
          end
        end
        default: begin
          r_state <= ST_EMPTY;
        end
      endcase
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (i_clear_err) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign o_frame_out   = r_frame;
  assign o_frame_valid = (r_state == ST_FULL);
  assign o_byte_count  = r_count;
  assign o_overrun     = r_overrun;
  assign o_timeout_err = r_timeout_err;
  assign o_chk_err     = r_chk_err;

endmodule

// File: tb/tb_rx_frame_assembler.sv
module tb_rx_frame_assembler;

  localparam int NB  = 3;
  localparam int TMO = 20;
`ifdef RX_FRAME_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk     = 1'b0;
  logic        rst     = 1'b0;
  logic        strobe  = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        ready   = 1'b0;
  logic        clear   = 1'b0;

  logic [23:0] d_frame, l_frame;
  logic        d_valid, l_valid;
  logic [1:0]  d_count, l_count;
  logic        d_ovr, l_ovr, d_tmo, l_tmo, d_chk, l_chk;

  rx_frame_assembler #(.DATA_W(8), .NUM_BYTES(NB), .TIMEOUT_CYC(TMO), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .i_byte_strobe(strobe), .i_byte_in(byte_in),
    .o_frame_out(d_frame), .o_frame_valid(d_valid), .i_frame_ready(ready),
    .o_byte_count(d_count), .o_overrun(d_ovr), .o_timeout_err(d_tmo),
    .o_chk_err(d_chk), .i_clear_err(clear));

  rx_frame_assembler #(.DATA_W(8), .NUM_BYTES(NB), .TIMEOUT_CYC(TMO), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .i_byte_strobe(strobe), .i_byte_in(byte_in),
    .o_frame_out(l_frame), .o_frame_valid(l_valid), .i_frame_ready(ready),
    .o_byte_count(l_count), .o_overrun(l_ovr), .o_timeout_err(l_tmo),
    .o_chk_err(l_chk), .i_clear_err(clear));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (word list per frame) ----------------
  logic [7:0]  m_words[$];
  logic [23:0] sb_msb[$];
  logic [23:0] sb_lsb[$];
  int          m_timer = 0;
  bit          m_prev = 1'b0, m_full = 1'b0, m_ovr = 1'b0, m_tmo = 1'b0, m_chk = 1'b0;
  bit          m_was_rst = 1'b0;
  logic [23:0] m_fm = 24'h0, m_fl = 24'h0;

  initial begin
    bit edge_s, accept, complete, drop;
    logic [23:0] nm, nl;
    logic [7:0]  x;
    forever begin
      @(posedge clk);
      if (!rst) begin
        m_words.delete(); sb_msb.delete(); sb_lsb.delete();
        m_prev = 1'b0; m_timer = 0; m_full = 1'b0; m_ovr = 1'b0;
        m_tmo = 1'b0; m_chk = 1'b0; m_fm = 24'h0; m_fl = 24'h0; m_was_rst = 1'b1;
      end else begin
        m_was_rst = 1'b0;
        edge_s = strobe && !m_prev;
        m_prev = strobe;
        accept = m_full && ready;
        complete = 1'b0; m_tmo = 1'b0; m_chk = 1'b0;
        nm = 24'h0; nl = 24'h0; x = 8'h00;
        if (edge_s) begin
          m_words.push_back(byte_in);
          m_timer = 0;
          if (m_words.size() == NB + CSUM) begin
            for (int i = 0; i < NB; i++) begin
              nm = (nm << 8) | 24'(m_words[i]);
              nl = nl | (24'(m_words[i]) << (8 * i));
              x  = x ^ m_words[i];
            end
            if (CSUM == 0 || x == m_words[NB]) complete = 1'b1;
            else m_chk = 1'b1;
            m_words.delete();
          end
        end else if (m_words.size() > 0) begin
          m_timer++;
          if (m_timer == TMO) begin
            m_words.delete(); m_timer = 0; m_tmo = 1'b1;
          end
        end
        drop = complete && m_full && !accept;
        if (complete && !drop) begin
          m_full = 1'b1; m_fm = nm; m_fl = nl;
          sb_msb.push_back(nm); sb_lsb.push_back(nl);
        end else if (accept && !complete) begin
          m_full = 1'b0;
        end
        if (drop) m_ovr = 1'b1;
        else if (clear) m_ovr = 1'b0;
      end
      @(negedge clk);
      chk("valid", 32'(d_valid), 32'(m_full));
      chk("valid_lsb", 32'(l_valid), 32'(m_full));
      chk("byte_count", 32'(d_count), 32'(m_words.size()));
      chk("overrun", 32'(d_ovr), 32'(m_ovr));
      chk("timeout_err", 32'(d_tmo), 32'(m_tmo));
      chk("chk_err", 32'(d_chk), 32'(m_chk));
      if (m_full || m_was_rst) begin
        chk("frame_msb", 32'(d_frame), 32'(m_fm));
        chk("frame_lsb", 32'(l_frame), 32'(m_fl));
      end
    end
  end

  // ---------------- monitor: pops scoreboard on each handshake ----------------
  logic [23:0] last_acc = 24'h0;
  int tmo_pulses = 0, chk_pulses = 0, valid_cycles = 0;

  initial begin
    logic [23:0] em, el;
    forever begin
      @(negedge clk);
      if (d_tmo) tmo_pulses++;
      if (d_chk) chk_pulses++;
      if (d_valid) valid_cycles++;
      if (rst && d_valid && ready) begin
        if (sb_msb.size() == 0) begin
          chk("sb_unexpected_frame", 32'(d_frame), 32'hFFFFFFFF);
        end else begin
          em = sb_msb.pop_front();
          el = sb_lsb.pop_front();
          chk("sb_frame_msb", 32'(d_frame), 32'(em));
          chk("sb_frame_lsb", 32'(l_frame), 32'(el));
          last_acc = d_frame;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  bit rand_ready = 1'b0;

  task automatic step();
    @(posedge clk);
    #2;
    if (rand_ready) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_word(input logic [7:0] w, input int hold, input int gap, input int rdy);
    logic prev_r;
    prev_r = ready;
    strobe = 1'b1;
    byte_in = w;
    if (rdy >= 0) ready = 1'(rdy);
    repeat (hold) step();
    strobe = 1'b0;
    byte_in = 8'($urandom);
    if (rdy >= 0) ready = prev_r;
    repeat (gap + 1) step();
  endtask

  task automatic send_frame(input logic [23:0] f, input bit bad, input int hold,
                            input int gap, input int rdy_last);
    logic [7:0] w, x;
    x = 8'h00;
    for (int i = 0; i < NB; i++) begin
      w = f[8*(NB-1-i) +: 8];
      x = x ^ w;
      send_word(w, hold, gap, (CSUM == 0 && i == NB - 1) ? rdy_last : -1);
    end
    if (CSUM != 0) send_word(x ^ (bad ? 8'h01 : 8'h00), hold, gap, rdy_last);
  endtask

  initial begin
    int n, r;
    repeat (3) step();

    // Strobe already high when reset releases counts as one edge.
    strobe = 1'b1; byte_in = 8'hA5;
    rst = 1'b1;
    step();
    chk("edge_at_reset_release", 32'(d_count), 32'd1);
    strobe = 1'b0;
    repeat (TMO + 3) step();

    // Basic frame, ready high: valid for exactly one cycle.
    ready = 1'b1;
    valid_cycles = 0;
    send_frame(24'h123456, 1'b0, 1, 0, -1);
    repeat (2) step();
    chk("frame_123456", 32'(last_acc), 32'h123456);
    chk("valid_one_cycle", 32'(valid_cycles), 32'd1);

    // Long strobe counts once, then times out.
    n = tmo_pulses;
    send_word(8'hAA, 10, 0, -1);
    chk("held_strobe_count", 32'(d_count), 32'd1);
    repeat (TMO + 2) step();
    chk("timeout_pulse", 32'(tmo_pulses), 32'(n + 1));
    chk("count_after_timeout", 32'(d_count), 32'd0);

    // Overrun: two frames with ready low.
    ready = 1'b0;
    send_frame(24'h010203, 1'b0, 1, 0, -1);
    send_frame(24'h040506, 1'b0, 1, 0, -1);
    chk("overrun_set", 32'(d_ovr), 32'd1);
    chk("held_frame", 32'(d_frame), 32'h010203);
    clear = 1'b1; step(); clear = 1'b0;
    chk("overrun_cleared", 32'(d_ovr), 32'd0);
    // Completion in the same cycle as accept: new frame loads, valid stays.
    send_frame(24'h070809, 1'b0, 1, 0, 1);
    chk("swap_valid", 32'(d_valid), 32'd1);
    chk("swap_frame", 32'(d_frame), 32'h070809);
    chk("swap_no_overrun", 32'(d_ovr), 32'd0);
    ready = 1'b1; step();

    // After a timeout the next frame assembles normally.
    send_word(8'h77, 1, TMO + 2, -1);
    send_frame(24'h112233, 1'b0, 1, 0, -1);
    step();
    chk("frame_112233", 32'(last_acc), 32'h112233);

    send_frame(24'h010204, 1'b0, 2, 1, -1);
    step();
    chk("frame_010204", 32'(last_acc), 32'h010204);
`ifdef RX_FRAME_CHECKSUM_EN
    n = chk_pulses;
    valid_cycles = 0;
    send_frame(24'h010204, 1'b1, 1, 0, -1);
    step();
    chk("chk_err_pulse", 32'(chk_pulses), 32'(n + 1));
    chk("chk_bad_no_valid", 32'(valid_cycles), 32'd0);
`endif

    // Reset mid-frame.
    send_word(8'h01, 1, 0, -1);
    send_word(8'h02, 1, 0, -1);
    rst = 1'b0; step();
    chk("rst_count", 32'(d_count), 32'd0);
    chk("rst_frame", 32'(d_frame), 32'd0);
    rst = 1'b1; step();

    // Randomized traffic.
    rand_ready = 1'b1;
    for (int it = 0; it < 250; it++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        repeat (TMO + 2) step();
      end else if (r == 1) begin
        clear = 1'b1; step(); clear = 1'b0;
      end else if (r == 2) begin
        rst = 1'b0; step(); rst = 1'b1;
      end else if (r <= 5) begin
        send_word(8'($urandom), int'($urandom_range(1, 3)), int'($urandom_range(0, 2)), -1);
      end else begin
        send_frame(24'($urandom), ($urandom_range(0, 3) == 0), int'($urandom_range(1, 3)),
                   int'($urandom_range(0, 2)), -1);
      end
    end
    rand_ready = 1'b0;
    ready = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
